// File: rtl/lifo_frame_reverser_if.sv
// lifo_frame_reverser_if: valid/ready beat stream with last marker
interface lifo_frame_reverser_if #(parameter int DATA_WIDTH = 8) ();
  logic [DATA_WIDTH-1:0] data;
  logic valid;
  logic last;
  logic ready;
  modport master(output data, valid, last, input ready);
  modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/lifo_frame_reverser.sv
// lifo_frame_reverser: pushes a frame into an external lifo, then pops it out reversed
module lifo_frame_reverser #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lifo_frame_reverser_if.slave  s,
  lifo_frame_reverser_if.master m,
  output logic [DATA_WIDTH-1:0] lifo_data_wr,
  output logic                  lifo_wr_en,
  output logic                  lifo_rd_en,
  input  logic [DATA_WIDTH-1:0] lifo_data_rd,
  input  logic                  lifo_full,
  input  logic                  lifo_empty,
  output logic                  frame_ovf
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic m_valid, m_valid_n, m_last, m_last_n, ovf_n;
  logic accept, push, pop, op_d;
  assign s.ready = state == FILL;
  assign m.data = lifo_data_rd;
  assign m.valid = m_valid;
  assign m.last = m_last;
  assign lifo_data_wr = s.data;
  assign lifo_wr_en = push;
  assign lifo_rd_en = pop;
  // push only in FILL with room, pop only in DRAIN when output slot frees
  always_comb begin
    accept = state == FILL && s.valid;
    push = accept && cnt != CW'(DEPTH) && rst_n;
    pop = state == DRAIN && cnt != '0 && (!m_valid || m.ready) && rst_n;
    cnt_n = push ? cnt + CW'(1) : pop ? cnt - CW'(1) : cnt;
    m_valid_n = pop ? 1'b1 : m.ready ? 1'b0 : m_valid;
    m_last_n = pop ? cnt == CW'(1) : m_last;
    ovf_n = accept && cnt == CW'(DEPTH);
    state_n = state == FILL ? (accept && s.last ? DRAIN : FILL)
                            : (m_valid && m.ready && m_last ? FILL : DRAIN);
  end
  // state, occupancy and output beat registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      cnt <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      frame_ovf <= 1'b0;
      op_d <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      m_valid <= m_valid_n;
      m_last <= m_last_n;
      frame_ovf <= ovf_n;
      op_d <= push || pop;
    end
  end
  a_no_bypass: assert property (@(posedge clk) disable iff (!rst_n) !(lifo_wr_en && lifo_rd_en));
  a_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (!op_d && !lifo_wr_en && !lifo_rd_en) |-> lifo_empty == (cnt == '0));
  a_full: assert property (@(posedge clk) disable iff (!rst_n) lifo_full |-> cnt == CW'(DEPTH));
endmodule
